// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE sequencer for the i281 core.
// Sits between controllogic and the datapath. State-changing enables reach the
// datapath only in EXECUTE. Adds run/stop, single-step, halt request and a
// saturating retired-instruction counter.
//
// Build option: define BREAKPOINT_EN to halt when the post-instruction PC
// matches bp_addr. Without it, bp_addr/bp_valid are ignored and bp_hit is 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | out of reset, waiting for run or step
// FETCH    | ir_load strobe, enables masked
// DECODE   | controllogic settles, enables masked
// EXECUTE  | full control word issued, instruction retires
// HALTED   | stopped by one-shot, run=0, halt_req or breakpoint
module cpu_sequencer #(
   parameter int          PC_W    = 6,
   parameter int          CNT_W   = 16,
   parameter logic [1:18] WE_MASK = 18'b001000000100000110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic [1:18]      ctrl_in,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_valid,
   output logic [1:18]      ctrl_out,
   output logic             ir_load,
   output logic [2:0]       state_out,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count,
   output logic             bp_hit
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_HALTED  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             oneshot_q, oneshot_d;
   logic             run_q;
   logic [1:18]      ctrl_q;
   logic             ir_load_q;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bp_match;
   logic             bp_set;
   logic             bp_clr;

   // Next-state decode; halt_req dominates both restart sources in HALTED.
   always_comb begin
      state_d   = state_q;
      oneshot_d = oneshot_q;
      bp_set    = 1'b0;
      bp_clr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d   = S_FETCH;
               oneshot_d = 1'b0;
            end else if (step) begin
               state_d   = S_FETCH;
               oneshot_d = 1'b1;
            end
         end
         S_FETCH: begin
            // A breakpoint turns the speculative fetch into a stop before
            // any enable of the next instruction is issued.
            if (bp_match) begin
               state_d = S_HALTED;
               bp_set  = 1'b1;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (oneshot_q || !run || halt_req) state_d = S_HALTED;
            else                               state_d = S_FETCH;
         end
         S_HALTED: begin
            if (!halt_req) begin
               if (run && !run_q) begin
                  state_d   = S_FETCH;
                  oneshot_d = 1'b0;
                  bp_clr    = 1'b1;
               end else if (step) begin
                  state_d   = S_FETCH;
                  oneshot_d = 1'b1;
                  bp_clr    = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM register with outputs registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         oneshot_q <= 1'b0;
         run_q     <= 1'b0;
         ctrl_q    <= '0;
         ir_load_q <= 1'b0;
         halted_q  <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         oneshot_q <= oneshot_d;
         run_q     <= run;
         ir_load_q <= (state_d == S_FETCH);
         halted_q  <= (state_d == S_IDLE) || (state_d == S_HALTED);
         case (state_d)
            S_EXECUTE: ctrl_q <= ctrl_in;
            S_IDLE:    ctrl_q <= '0;
            default:   ctrl_q <= ctrl_in & ~WE_MASK;
         endcase
         if ((state_q == S_EXECUTE) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_ONE;
      end
   end

`ifdef BREAKPOINT_EN
   logic bp_chk_q;
   logic bp_hit_q;

   assign bp_match = bp_chk_q && bp_valid && (pc_in == bp_addr);

   // Arm the compare for the cycle right after a free-run EXECUTE, when
   // pc_in reflects the retired instruction; bp_hit is sticky until restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         bp_chk_q <= 1'b0;
         bp_hit_q <= 1'b0;
      end else begin
         bp_chk_q <= (state_q == S_EXECUTE) && (state_d == S_FETCH);
         if (bp_set)      bp_hit_q <= 1'b1;
         else if (bp_clr) bp_hit_q <= 1'b0;
      end
   end

   assign bp_hit = bp_hit_q;
`else
   logic unused_bp;

   assign bp_match  = 1'b0;
   assign bp_hit    = 1'b0;
   assign unused_bp = ^{bp_addr, bp_valid, pc_in, bp_set, bp_clr};
`endif

   assign ctrl_out    = ctrl_q;
   assign ir_load     = ir_load_q;
   assign state_out   = state_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: free-run, single-step, halt request,
// reset abort, counter saturation (second instance with a 4-bit counter)
// and the breakpoint stop when BREAKPOINT_EN is defined.
module tb_cpu_sequencer;

   localparam logic [17:0] ALL1   = 18'h3FFFF;
   localparam logic [17:0] MASKED = 18'h37EF9;

   logic        clk = 1'b0;
   logic        reset, run, step, halt_req, bp_valid;
   logic [1:18] ctrl_in;
   logic [5:0]  pc_in, bp_addr;

   logic [1:18] ctrl_out, ctrl_out4;
   logic        ir_load, ir_load4, halted, halted4, bp_hit, bp_hit4;
   logic [2:0]  state_out, state_out4;
   logic [15:0] instr_count;
   logic [3:0]  instr_count4;

   int n_vec = 0;
   int n_err = 0;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
      .ctrl_in(ctrl_in), .pc_in(pc_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .ctrl_out(ctrl_out), .ir_load(ir_load), .state_out(state_out),
      .halted(halted), .instr_count(instr_count), .bp_hit(bp_hit)
   );

   cpu_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
      .ctrl_in(ctrl_in), .pc_in(pc_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .ctrl_out(ctrl_out4), .ir_load(ir_load4), .state_out(state_out4),
      .halted(halted4), .instr_count(instr_count4), .bp_hit(bp_hit4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
      ctrl_in = '0; pc_in = '0; bp_addr = '0; bp_valid = 1'b0;
      tick(); tick();
      chk("rst_state",  32'(state_out), 32'd0);
      chk("rst_ctrl",   32'(ctrl_out), 32'd0);
      chk("rst_irld",   32'(ir_load), 32'd0);
      chk("rst_halted", 32'(halted), 32'd1);
      chk("rst_count",  32'(instr_count), 32'd0);
      chk("rst_bphit",  32'(bp_hit), 32'd0);

      // free run, 9 cycles, then stop on run=0
      reset = 1'b0; run = 1'b1; ctrl_in = ALL1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("fr_state", 32'(state_out), 32'((i % 3) + 1));
         chk("fr_ctrl",  32'(ctrl_out), 32'(((i % 3) == 2) ? ALL1 : MASKED));
         chk("fr_irld",  32'(ir_load), 32'((i % 3) == 0));
         chk("fr_halted", 32'(halted), 32'd0);
      end
      run = 1'b0;
      tick();
      chk("fr_stop_state", 32'(state_out), 32'd4);
      chk("fr_stop_count", 32'(instr_count), 32'd3);
      chk("fr_stop_halted", 32'(halted), 32'd1);
      chk("fr_stop_ctrl", 32'(ctrl_out), 32'(MASKED));

      // single step; a second step during DECODE is ignored
      step = 1'b1;
      tick(); step = 1'b0;
      chk("st_fetch", 32'(state_out), 32'd1);
      chk("st_irld",  32'(ir_load), 32'd1);
      tick();
      chk("st_decode", 32'(state_out), 32'd2);
      step = 1'b1;
      tick(); step = 1'b0;
      chk("st_exec", 32'(state_out), 32'd3);
      chk("st_exec_ctrl", 32'(ctrl_out), 32'(ALL1));
      tick();
      chk("st_halt", 32'(state_out), 32'd4);
      chk("st_count", 32'(instr_count), 32'd4);
      tick(); tick();
      chk("st_noqueue_state", 32'(state_out), 32'd4);
      chk("st_noqueue_count", 32'(instr_count), 32'd4);

      // run rising, halt_req raised in DECODE
      run = 1'b1;
      tick();
      chk("hr_fetch", 32'(state_out), 32'd1);
      tick();
      chk("hr_decode", 32'(state_out), 32'd2);
      halt_req = 1'b1;
      tick();
      chk("hr_exec", 32'(state_out), 32'd3);
      tick();
      chk("hr_halt", 32'(state_out), 32'd4);
      chk("hr_count", 32'(instr_count), 32'd5);
      run = 1'b0;
      tick();
      run = 1'b1;
      tick();
      chk("hr_run_blocked", 32'(state_out), 32'd4);
      run = 1'b0; step = 1'b1;
      tick(); step = 1'b0;
      chk("hr_step_blocked", 32'(state_out), 32'd4);
      tick();
      chk("hr_step_noqueue", 32'(state_out), 32'd4);
      halt_req = 1'b0;

      // reset during EXECUTE aborts
      step = 1'b1;
      tick(); step = 1'b0;
      tick(); tick();
      chk("ra_exec", 32'(state_out), 32'd3);
      reset = 1'b1;
      tick();
      chk("ra_state",  32'(state_out), 32'd0);
      chk("ra_ctrl",   32'(ctrl_out), 32'd0);
      chk("ra_count",  32'(instr_count), 32'd0);
      chk("ra_halted", 32'(halted), 32'd1);
      chk("ra_irld",   32'(ir_load), 32'd0);
      reset = 1'b0;

      // 17 instructions: 16-bit counter reads 17, 4-bit counter sticks at F
      run = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      chk("sat_decode", 32'(state_out), 32'd2);
      run = 1'b0;
      tick();
      chk("sat_exec", 32'(state_out), 32'd3);
      tick();
      chk("sat_halt",    32'(state_out), 32'd4);
      chk("sat_count16", 32'(instr_count), 32'd17);
      chk("sat_count4",  32'(instr_count4), 32'hF);

      // breakpoint at PC=5 with PC advancing 3,4,5
      bp_valid = 1'b1; bp_addr = 6'd5; pc_in = 6'd3; run = 1'b1;
      tick(); tick(); tick();
      chk("bp_exec1", 32'(state_out), 32'd3);
      pc_in = 6'd4;
      tick();
      chk("bp_fetch2", 32'(state_out), 32'd1);
      tick();
      chk("bp_decode2", 32'(state_out), 32'd2);
      tick();
      chk("bp_exec2", 32'(state_out), 32'd3);
      pc_in = 6'd5;
      tick();
      chk("bp_fetch3", 32'(state_out), 32'd1);
      tick();
`ifdef BREAKPOINT_EN
      chk("bp_stop_state", 32'(state_out), 32'd4);
      chk("bp_stop_hit",   32'(bp_hit), 32'd1);
      chk("bp_stop_ctrl",  32'(ctrl_out), 32'(MASKED));
      tick();
      chk("bp_no_exec", 32'(state_out), 32'd4);
      chk("bp_count",   32'(instr_count), 32'd19);
      run = 1'b0; step = 1'b1;
      tick(); step = 1'b0;
      chk("bp_step_fetch", 32'(state_out), 32'd1);
      chk("bp_step_clr",   32'(bp_hit), 32'd0);
`else
      chk("bp_off_state", 32'(state_out), 32'd2);
      chk("bp_off_hit",   32'(bp_hit), 32'd0);
      tick();
      chk("bp_off_exec",  32'(state_out), 32'd3);
      chk("bp_off_count", 32'(instr_count), 32'd19);
`endif
      chk("bp_count4", 32'(instr_count4), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the i281 core.
- Sits between the instruction register / opcode decoder + controllogic and the datapath.
- Each instruction takes FETCH, DECODE, EXECUTE cycles; state-changing control bits reach the datapath only in EXECUTE.
- Adds run/stop, single-step, halt request and a saturating retired-instruction counter for board-level debug.

Parameters:
PC_W, 6, width of program counter / breakpoint address (64-word code memory)
CNT_W, 16, width of retired-instruction counter
WE_MASK, 18'b001000000100000110, bits of control word [1:18] that are state-changing enables; these bits are forced 0 outside EXECUTE

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = free-run, 0 = stop after current instruction
step  input  1  one-cycle pulse; execute exactly one instruction from HALTED
halt_req  input  1  level; stop after current instruction
ctrl_in  input  [1:18]  control word from controllogic
pc_in  input  PC_W  current PC value from datapath
bp_addr  input  PC_W  breakpoint address (used only with BREAKPOINT_EN)
bp_valid  input  1  breakpoint armed (used only with BREAKPOINT_EN)
ctrl_out  output  [1:18]  gated control word to datapath
ir_load  output  1  instruction register load strobe
state_out  output  3  encoded state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALTED=4
halted  output  1  1 in IDLE or HALTED
instr_count  output  CNT_W  retired instructions, saturating
bp_hit  output  1  sticky: last stop caused by breakpoint

Behaviour:
- Reset (sync, high): state=IDLE; ctrl_out=0; ir_load=0; instr_count=0; bp_hit=0; halted=1. Reset mid-instruction aborts it; no partial EXECUTE is issued.
- IDLE: run=1 -> FETCH next cycle; step=1 -> FETCH in one-shot mode; otherwise stay.
- FETCH (1 cycle): ir_load=1; ctrl_out = ctrl_in & ~WE_MASK. -> DECODE.
- DECODE (1 cycle): ir_load=0; ctrl_out = ctrl_in & ~WE_MASK; controllogic output settles. -> EXECUTE.
- EXECUTE (1 cycle): ctrl_out = ctrl_in unmasked; instr_count += 1, saturating at all-ones.
- EXECUTE exit: -> HALTED if one-shot mode, run=0, halt_req=1 or breakpoint hit; else -> FETCH.
- HALTED: ctrl_out = ctrl_in & ~WE_MASK.
  - step pulse with halt_req=0 -> FETCH in one-shot mode; clears bp_hit.
  - run rising (run=1 and halt_req=0) -> FETCH free-run; clears bp_hit.
  - halt_req=1 blocks both step and run (halt wins on simultaneous events).
- Latency: 3 cycles per instruction, giving 1 EXECUTE pulse per 3 clocks in free-run. A step from HALTED yields EXECUTE exactly 3 cycles after the step cycle.
- Stopping on run=0 or halt_req=1 never truncates an instruction already in FETCH or DECODE; it completes through EXECUTE.
- step pulses outside IDLE/HALTED are ignored (not queued).
- Run-rising detection uses a registered copy of run, cleared by reset.
- halted = (state==IDLE) | (state==HALTED), registered with the state.

Optional Feature:
BREAKPOINT_EN
- Defined: in EXECUTE, if bp_valid=1 and the PC value after the instruction (pc_in sampled in the following cycle) equals bp_addr, transition to HALTED and set bp_hit=1. Implement by comparing in the first cycle after EXECUTE, then overriding FETCH -> HALTED with ctrl_out masked, so no extra instruction executes.
- Not defined: bp_addr/bp_valid are ignored; bp_hit is tied 0; no comparator is synthesised.

Test Plan:
- Reset then run=1, ctrl_in=18'h3FFFF for 9 cycles -> state sequence 1,2,3,1,2,3,1,2,3; ctrl_out=18'h3FFFF only in state 3 and 18'h3FFFF & ~WE_MASK otherwise; instr_count=3.
- From HALTED, step pulse for 1 cycle -> ir_load=1 next cycle, one EXECUTE, return to HALTED; instr_count increments by exactly 1; further step during DECODE is ignored.
- Free-run with halt_req raised during DECODE -> EXECUTE still occurs; state 4 next; subsequent run=1 with halt_req=1 stays 4; step and halt_req in the same cycle -> stays 4.
- Assert reset during EXECUTE -> next cycle state=0, ctrl_out=0, instr_count=0, halted=1.
- Preload instr_count near max (CNT_W=4, run 17 instructions) -> count stops at 4'hF.
- BREAKPOINT_EN: bp_valid=1, bp_addr=6'd5, PC advancing 3,4,5 -> halts after the instruction producing PC=5; bp_hit=1; no EXECUTE issued at PC=5 until the next step.
